encoder_speed_estimator: RTL and testbench

Quadrature encoder front end for the BLDC velocity loop. Synchronises and deglitches the A/B encoder lines, decodes them 4x into a signed 32-bit position count, and on every 20 kHz control tick produces the moving-averaged per-sample displacement. That displacement is the signed 32-bit `actual_speed` in ticks/sample that the downstream PI speed controller consumes. It also exposes position and a sticky illegal-transition flag for AXI readback.

---
 rtl/bldc_pkg.sv | 49 ++++
 rtl/quad_glitch_filter.sv | 49 ++++
 rtl/encoder_speed_estimator.sv | 147 ++++++++++++++
 tb/tb_encoder_speed_estimator.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bldc_pkg.sv
// Shared BLDC definitions: datapath width, quadrature state encoding and the
// quadrature step decoder. Also used by the hall-sensor block.
//   quad_decode(prev_ab, cur_ab) -> {step (signed -1/0/+1), illegal}
//   {A,B} forward order: 00 -> 10 -> 11 -> 01 -> 00
package bldc_pkg;

   localparam int SPEED_W = 32;

   localparam logic [1:0] QUAD_S0 = 2'b00;
   localparam logic [1:0] QUAD_S1 = 2'b10;
   localparam logic [1:0] QUAD_S2 = 2'b11;
   localparam logic [1:0] QUAD_S3 = 2'b01;

   typedef struct packed {
      logic signed [1:0] step;
      logic              illegal;
   } quad_step_t;

   // Next {A,B} state in the forward direction.
   function automatic logic [1:0] quad_next(input logic [1:0] ab);
      logic [1:0] nxt;
      case (ab)
         QUAD_S0: nxt = QUAD_S1;
         QUAD_S1: nxt = QUAD_S2;
         QUAD_S2: nxt = QUAD_S3;
         default: nxt = QUAD_S0;
      endcase
      return nxt;
   endfunction

   // Both bits changing at once cannot be attributed to a direction.
   function automatic quad_step_t quad_decode(input logic [1:0] prev_ab,
                                              input logic [1:0] cur_ab);
      quad_step_t res;
      res.step    = 2'sd0;
      res.illegal = 1'b0;
      if (cur_ab != prev_ab) begin
         if (cur_ab == quad_next(prev_ab)) begin
            res.step = 2'sd1;
         end else if (prev_ab == quad_next(cur_ab)) begin
            res.step = -2'sd1;
         end else begin
            res.illegal = 1'b1;
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/quad_glitch_filter.sv
// Two-flop synchroniser followed by a persistence filter for one encoder line.
//   clk, reset_n : system clock, synchronous active-low reset
//   raw          : asynchronous encoder input
//   filtered     : level that changes only after the synchronised input has
//                  differed from it for GLITCH_CYCLES consecutive cycles
module quad_glitch_filter #(
   parameter int unsigned GLITCH_CYCLES = 4
) (
   input  logic clk,
   input  logic reset_n,
   input  logic raw,
   output logic filtered
);

   localparam int unsigned CNT_W = (GLITCH_CYCLES > 1) ? $clog2(GLITCH_CYCLES) : 1;

   logic [1:0]       sync_q;
   logic             filt_q, filt_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      filt_d = filt_q;
      cnt_d  = cnt_q;
      if (sync_q[1] == filt_q) begin
         // Any return to the current level restarts the persistence count.
         cnt_d = '0;
      end else if (cnt_q == CNT_W'(GLITCH_CYCLES - 1)) begin
         filt_d = sync_q[1];
         cnt_d  = '0;
      end else begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         sync_q <= '0;
         filt_q <= 1'b0;
         cnt_q  <= '0;
      end else begin
         sync_q <= {sync_q[0], raw};
         filt_q <= filt_d;
         cnt_q  <= cnt_d;
      end
   end

   assign filtered = filt_q;

endmodule

// File: rtl/encoder_speed_estimator.sv
// Quadrature encoder front end: deglitched 4x decode into a wrapping position,
// per-tick displacement and a 2^AVG_LOG2-deep moving average of it.
//   clk, reset_n    : 100 MHz clock, synchronous active-low reset
//   clk_20k_enable  : control-tick strobe; latches the window displacement
//   enc_a, enc_b    : raw encoder lines
//   dir_invert      : negate counting direction
//   pos_load(_value): overwrite position (and window start)
//   err_clear       : clear the sticky illegal-transition flag
//   actual_speed    : averaged ticks/sample, speed_valid pulses on update
//   position        : signed wrapping count, enc_error sticky error flag
module encoder_speed_estimator
   import bldc_pkg::*;
#(
   parameter int unsigned AVG_LOG2      = 2,
   parameter int unsigned GLITCH_CYCLES = 4
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               clk_20k_enable,
   input  logic               enc_a,
   input  logic               enc_b,
   input  logic               dir_invert,
   input  logic               pos_load,
   input  logic [SPEED_W-1:0] pos_load_value,
   input  logic               err_clear,
   output logic [SPEED_W-1:0] actual_speed,
   output logic               speed_valid,
   output logic [SPEED_W-1:0] position,
   output logic               enc_error
);

   localparam int unsigned DEPTH       = 1 << AVG_LOG2;
   localparam int unsigned SUM_W       = SPEED_W + AVG_LOG2;
   localparam int unsigned PTR_W       = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
   // Synchroniser plus filter latency, so prev_ab sees the settled power-up level.
   localparam int unsigned INIT_CYCLES = GLITCH_CYCLES + 2;
   localparam int unsigned INIT_W      = $clog2(INIT_CYCLES + 1);

   localparam logic StInit = 1'b0;
   localparam logic StRun  = 1'b1;

   logic filt_a, filt_b;

   quad_glitch_filter #(.GLITCH_CYCLES(GLITCH_CYCLES)) u_filt_a (
      .clk      (clk),
      .reset_n  (reset_n),
      .raw      (enc_a),
      .filtered (filt_a)
   );

   quad_glitch_filter #(.GLITCH_CYCLES(GLITCH_CYCLES)) u_filt_b (
      .clk      (clk),
      .reset_n  (reset_n),
      .raw      (enc_b),
      .filtered (filt_b)
   );

   logic                     state_q, state_d;
   logic [INIT_W-1:0]        init_cnt_q, init_cnt_d;
   logic [1:0]               prev_ab_q, cur_ab;
   quad_step_t               dec;
   logic signed [1:0]        step_raw, step;
   logic [SPEED_W-1:0]       step_ext;
   logic                     illegal;
   logic [SPEED_W-1:0]       position_q, position_d;
   logic [SPEED_W-1:0]       snapshot_q, snapshot_d;
   logic [SPEED_W-1:0]       delta_q, delta_d;
   logic                     err_q, err_d;
   logic                     avg_pend_q, valid_q;
   logic [SPEED_W-1:0]       ring_q [DEPTH];
   logic [SPEED_W-1:0]       oldest;
   logic [PTR_W-1:0]         wr_ptr_q, wr_ptr_d;
   logic signed [SUM_W-1:0]  sum_q, sum_d;
   logic [SPEED_W-1:0]       speed_q, speed_d;

   always_comb begin
      cur_ab   = {filt_a, filt_b};
      dec      = quad_decode(prev_ab_q, cur_ab);
      step_raw = (state_q == StRun) ? dec.step : 2'sd0;
      step     = dir_invert ? -step_raw : step_raw;
      step_ext = SPEED_W'(step);
      illegal  = (state_q == StRun) && dec.illegal;

      state_d    = state_q;
      init_cnt_d = init_cnt_q;
      if (state_q == StInit) begin
         if (init_cnt_q == INIT_W'(INIT_CYCLES)) begin
            state_d = StRun;
         end else begin
            init_cnt_d = init_cnt_q + INIT_W'(1);
         end
      end

      // Window bookkeeping uses pre-step values; a load restarts the window.
      delta_d    = clk_20k_enable ? (position_q - snapshot_q) : delta_q;
      snapshot_d = pos_load ? pos_load_value : (clk_20k_enable ? position_q : snapshot_q);
      position_d = pos_load ? pos_load_value : (position_q + step_ext);

      // A fresh illegal transition outranks a clear in the same cycle.
      err_d = illegal ? 1'b1 : (err_clear ? 1'b0 : err_q);

      oldest   = ring_q[wr_ptr_q];
      sum_d    = sum_q + SUM_W'($signed(delta_q)) - SUM_W'($signed(oldest));
      speed_d  = SPEED_W'(sum_d >>> AVG_LOG2);
      wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q    <= StInit;
         init_cnt_q <= '0;
         prev_ab_q  <= '0;
         position_q <= '0;
         snapshot_q <= '0;
         delta_q    <= '0;
         err_q      <= 1'b0;
         avg_pend_q <= 1'b0;
         valid_q    <= 1'b0;
         wr_ptr_q   <= '0;
         sum_q      <= '0;
         speed_q    <= '0;
         for (int i = 0; i < int'(DEPTH); i++) ring_q[i] <= '0;
      end else begin
         state_q    <= state_d;
         init_cnt_q <= init_cnt_d;
         prev_ab_q  <= cur_ab;
         position_q <= position_d;
         snapshot_q <= snapshot_d;
         delta_q    <= delta_d;
         err_q      <= err_d;
         avg_pend_q <= clk_20k_enable;
         valid_q    <= avg_pend_q;
         if (avg_pend_q) begin
            ring_q[wr_ptr_q] <= delta_q;
            sum_q            <= sum_d;
            speed_q          <= speed_d;
            wr_ptr_q         <= wr_ptr_d;
         end
      end
   end

   assign actual_speed = speed_q;
   assign speed_valid  = valid_q;
   assign position     = position_q;
   assign enc_error    = err_q;

endmodule

// File: tb/tb_encoder_speed_estimator.sv
module tb_encoder_speed_estimator;

   localparam int G = 4;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        en = 1'b0;
   logic        enc_a = 1'b0, enc_b = 1'b0;
   logic        dir_invert = 1'b0, pos_load = 1'b0, err_clear = 1'b0;
   logic [31:0] pos_load_value = '0;
   logic [31:0] speed2, pos2, speed0, pos0;
   logic        valid2, err2, valid0, err0;

   always #5 clk = ~clk;

   encoder_speed_estimator #(.AVG_LOG2(2), .GLITCH_CYCLES(G)) u_dut (
      .clk(clk), .reset_n(reset_n), .clk_20k_enable(en), .enc_a(enc_a), .enc_b(enc_b),
      .dir_invert(dir_invert), .pos_load(pos_load), .pos_load_value(pos_load_value),
      .err_clear(err_clear), .actual_speed(speed2), .speed_valid(valid2),
      .position(pos2), .enc_error(err2)
   );

   encoder_speed_estimator #(.AVG_LOG2(0), .GLITCH_CYCLES(G)) u_dut0 (
      .clk(clk), .reset_n(reset_n), .clk_20k_enable(en), .enc_a(enc_a), .enc_b(enc_b),
      .dir_invert(dir_invert), .pos_load(pos_load), .pos_load_value(pos_load_value),
      .err_clear(err_clear), .actual_speed(speed0), .speed_valid(valid0),
      .position(pos0), .enc_error(err0)
   );

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s at %0t: got 0x%08h, want 0x%08h", name, $time, act, exp);
         if (n_checks - n_pass >= 40) begin
            $display("%0d/%0d checks passed", n_pass, n_checks);
            $finish;
         end
      end
   endtask

   // ---------------- behavioural reference model ----------------
   // Filtered level = value the synchronised stream has held for the last G samples.
   // Position counts the quadrature phase difference; speed = floor(mean of last N deltas).
   logic [G+1:0] ha_h, hb_h;
   logic         mfa, mfb, mfa_p, mfb_p;
   int           cyc;
   logic [31:0]  m_pos, m_snap, m_delta, m_speed2, m_speed0;
   logic         m_err, m_valid, avg_due, live = 1'b0;
   int           dq[$];

   function automatic int qpos(input logic a, input logic b);
      case ({a, b})
         2'b00:   return 0;
         2'b10:   return 1;
         2'b11:   return 2;
         default: return 3;
      endcase
   endfunction

   function automatic logic [1:0] qcode(input int idx);
      case (idx & 3)
         0:       return 2'b00;
         1:       return 2'b10;
         2:       return 2'b11;
         default: return 2'b01;
      endcase
   endfunction

   function automatic logic win_all(input logic [G+1:0] h, input logic v);
      for (int j = 2; j <= G + 1; j++) if (h[j] !== v) return 1'b0;
      return 1'b1;
   endfunction

   function automatic logic [31:0] win_avg(input int l);
      longint s = 0;
      for (int i = 0; i < (1 << l); i++) if (i < dq.size()) s += longint'(dq[i]);
      return 32'(s >>> l);
   endfunction

   task automatic model_step();
      int  d, st;
      logic ill, due_next;
      if (!reset_n) begin
         ha_h = '0; hb_h = '0; mfa = 0; mfb = 0; mfa_p = 0; mfb_p = 0; cyc = 0;
         m_pos = '0; m_snap = '0; m_delta = '0; m_speed2 = '0; m_speed0 = '0;
         m_err = 0; m_valid = 0; avg_due = 0; dq.delete(); live = 1'b1;
      end else begin
         cyc++;
         m_valid = avg_due;
         if (avg_due) begin
            dq.push_front(int'(m_delta));
            if (dq.size() > 16) void'(dq.pop_back());
            m_speed2 = win_avg(2);
            m_speed0 = win_avg(0);
         end
         st = 0; ill = 0;
         if (cyc >= G + 4) begin
            d = (qpos(mfa, mfb) - qpos(mfa_p, mfb_p)) & 3;
            if (d == 1) st = 1;
            else if (d == 3) st = -1;
            else if (d == 2) ill = 1;
         end
         if (dir_invert) st = -st;
         mfa_p = mfa; mfb_p = mfb;
         ha_h = {ha_h[G:0], enc_a};
         hb_h = {hb_h[G:0], enc_b};
         if (win_all(ha_h, ~mfa)) mfa = ~mfa;
         if (win_all(hb_h, ~mfb)) mfb = ~mfb;
         due_next = en;
         if (en) begin
            m_delta = m_pos - m_snap;
            m_snap  = m_pos;
         end
         if (pos_load) begin
            m_pos  = pos_load_value;
            m_snap = pos_load_value;
         end else begin
            m_pos = m_pos + st;
         end
         if (ill) m_err = 1;
         else if (err_clear) m_err = 0;
         avg_due = due_next;
      end
   endtask

   initial forever begin
      @(posedge clk);
      model_step();
   end

   initial forever begin
      @(negedge clk);
      if (live) begin
         check("speed_avg4", speed2, m_speed2);
         check("valid_avg4", 32'(valid2), 32'(m_valid));
         check("pos_avg4", pos2, m_pos);
         check("err_avg4", 32'(err2), 32'(m_err));
         check("speed_avg1", speed0, m_speed0);
         check("valid_avg1", 32'(valid0), 32'(m_valid));
         check("pos_avg1", pos0, m_pos);
         check("err_avg1", 32'(err0), 32'(m_err));
      end
   end

   // ---------------- stimulus ----------------
   int qidx = 0;
   int got[$];

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic drive_q();
      {enc_a, enc_b} = qcode(qidx);
   endtask

   task automatic do_reset(input int idx);
      reset_n = 1'b0;
      qidx = idx;
      drive_q();
      tick(3);
      reset_n = 1'b1;
   endtask

   task automatic rotate(input int dir, input string tag);
      int exp_s[5] = '{25, 50, 75, 100, 100};
      do_reset(0);
      tick(20);
      got.delete();
      for (int i = 0; i < 5 * 5000 + 10; i++) begin
         if (valid2) got.push_back(int'(speed2));
         if (i % 50 == 0) begin
            qidx += dir;
            drive_q();
         end
         en = (i % 5000 == 4980);
         @(negedge clk);
      end
      en = 1'b0;
      check({tag, "_count"}, 32'(got.size()), 32'd5);
      for (int k = 0; k < 5; k++) begin
         if (k < got.size()) check({tag, "_speed"}, 32'(got[k]), 32'(exp_s[k]));
      end
   endtask

   initial begin
      int r;
      drive_q();
      // Scenario 1: reset while both lines high.
      qidx = 2;
      drive_q();
      tick(2);
      check("reset_speed", speed2, 32'd0);
      check("reset_valid", 32'(valid2), 32'd0);
      do_reset(2);
      tick(20);
      check("rst11_err", 32'(err2), 32'd0);
      check("rst11_pos", pos2, 32'd0);

      // Scenarios 2 and 3: steady rotation.
      rotate(1, "fwd");
      dir_invert = 1'b1;
      rotate(-1, "rev_inv");
      dir_invert = 1'b0;

      // Scenario 4: glitch rejection.
      do_reset(0);
      tick(20);
      enc_a = 1'b1;
      tick(3);
      enc_a = 1'b0;
      tick(20);
      check("glitch_pos", pos2, 32'd0);
      qidx = 1;
      drive_q();
      tick(20);
      check("stable_pos", pos2, 32'd1);

      // Scenario 5: illegal transitions and clear priority.
      qidx = 3;
      drive_q();
      tick(20);
      check("illegal_err", 32'(err2), 32'd1);
      check("illegal_pos", pos2, 32'd1);
      qidx = 1;
      drive_q();
      tick(G + 2);
      err_clear = 1'b1;
      tick(1);
      err_clear = 1'b0;
      tick(20);
      check("clr_vs_illegal_err", 32'(err2), 32'd1);
      err_clear = 1'b1;
      tick(1);
      err_clear = 1'b0;
      tick(2);
      check("clr_err", 32'(err2), 32'd0);

      // Scenario 6: wrap through 0x7FFFFFFF.
      pos_load = 1'b1;
      pos_load_value = 32'h7FFF_FFF0;
      tick(1);
      pos_load = 1'b0;
      tick(10);
      for (int i = 0; i < 32; i++) begin
         qidx++;
         drive_q();
         tick(10);
      end
      tick(20);
      check("wrap_pos", pos0, 32'h8000_0010);
      en = 1'b1;
      tick(1);
      en = 1'b0;
      tick(1);
      check("wrap_valid", 32'(valid0), 32'd1);
      check("wrap_speed", speed0, 32'd32);

      // Randomised traffic against the model.
      do_reset(qidx);
      tick(20);
      for (int i = 0; i < 10000; i++) begin
         r = $urandom_range(0, 99);
         if (r < 10) qidx += 1;
         else if (r < 18) qidx -= 1;
         else if (r < 19) qidx += 2;
         drive_q();
         en = ($urandom_range(0, 49) == 0) || (i >= 7000 && i < 7004);
         pos_load = ($urandom_range(0, 999) == 0);
         pos_load_value = $urandom;
         err_clear = ($urandom_range(0, 199) == 0);
         if ($urandom_range(0, 1999) == 0) dir_invert = ~dir_invert;
         if (i == 5000) reset_n = 1'b0;
         if (i == 5003) reset_n = 1'b1;
         @(negedge clk);
      end
      en = 1'b0;
      pos_load = 1'b0;
      err_clear = 1'b0;
      tick(10);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
